// File: rtl/traffic_pkg.sv
// Shared light-code, lamp and fault-code definitions for the traffic-light datapath,
// plus the light-code to lamp decode.
package traffic_pkg;

    localparam logic [1:0] TL_RED     = 2'b00;
    localparam logic [1:0] TL_YELLOW  = 2'b01;
    localparam logic [1:0] TL_GREEN   = 2'b10;
    localparam logic [1:0] TL_INVALID = 2'b11;

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_CONFLICT = 2'b01;
    localparam logic [1:0] FC_INVALID  = 2'b10;
    localparam logic [1:0] FC_STALE    = 2'b11;

    typedef enum logic [1:0] {
        StNormal,
        StPending,
        StFault
    } state_t;

    function automatic logic [2:0] decode_lamp(input logic [1:0] code);
        logic [2:0] lamp;
        case (code)
            TL_RED:    lamp = LAMP_R;
            TL_YELLOW: lamp = LAMP_Y;
            TL_GREEN:  lamp = LAMP_G;
            default:   lamp = LAMP_OFF;
        endcase
        return lamp;
    endfunction

endpackage

// File: rtl/blink_gen.sv
// Fault-flash phase generator: phase is 1 for BLINK_HALF cycles after a restart,
// then 0 for BLINK_HALF cycles, repeating.
module blink_gen #(
    parameter int unsigned BLINK_HALF = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic phase
);

    localparam int unsigned CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          on_q, on_d;

    always_comb begin
        cnt_d = cnt_q;
        on_d  = on_q;
        if (restart) begin
            cnt_d = '0;
            on_d  = 1'b1;
        end else if (cnt_q == CW'(BLINK_HALF - 1)) begin
            cnt_d = '0;
            on_d  = ~on_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            on_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            on_q  <= on_d;
        end
    end

    assign phase = on_q;

endmodule

// File: rtl/lamp_safety_driver.sv
// Lamp driver and independent safety monitor: decodes light codes to one-hot lamps and
// latches a flashing-red fault on conflicting, invalid or stale commands.
module lamp_safety_driver
    import traffic_pkg::*;
#(
    parameter int unsigned CONFLICT_CYCLES = 3,
    parameter int unsigned BLINK_HALF      = 50,
    parameter int unsigned WDOG_CYCLES     = 3000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] TL1,
    input  logic [1:0] TL2,
    input  logic       clr_fault,
    output logic [2:0] lamp1,
    output logic [2:0] lamp2,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam int unsigned WCW = $clog2(WDOG_CYCLES + 1);

    state_t         state_q, state_d;
    logic [3:0]     unsafe_cnt_q, unsafe_cnt_d;
    logic [WCW-1:0] stale_cnt_q, stale_cnt_d;
    logic [3:0]     prev_q;
    logic [2:0]     lamp1_q, lamp1_d, lamp2_q, lamp2_d;
    logic [1:0]     code_q, code_d;
    logic           conflict, invalid, unsafe, reached, stale_hit, restart, phase;

    function automatic logic is_go(input logic [1:0] code);
        return (code == TL_YELLOW) || (code == TL_GREEN);
    endfunction

    assign conflict = is_go(TL1) && is_go(TL2);
    assign invalid  = (TL1 == TL_INVALID) || (TL2 == TL_INVALID);
    assign unsafe   = conflict || invalid;

    always_comb begin
        unsafe_cnt_d = '0;
        if (unsafe) begin
            unsafe_cnt_d = (unsafe_cnt_q == 4'hf) ? unsafe_cnt_q : unsafe_cnt_q + 1'b1;
        end
        stale_cnt_d = '0;
        if ({TL1, TL2} == prev_q) begin
            stale_cnt_d = (stale_cnt_q == WCW'(WDOG_CYCLES)) ? stale_cnt_q
                                                              : stale_cnt_q + 1'b1;
        end
        // Count includes the current cycle, so CONFLICT_CYCLES unsafe samples trip the fault.
        reached   = unsafe_cnt_d >= 4'(CONFLICT_CYCLES);
        stale_hit = stale_cnt_d == WCW'(WDOG_CYCLES);

        state_d = state_q;
        case (state_q)
            StNormal: begin
                if (unsafe) state_d = reached ? StFault : StPending;
                if (stale_hit) state_d = StFault;
            end
            StPending: begin
                if (!unsafe) state_d = StNormal;
                else if (reached) state_d = StFault;
                if (stale_hit) state_d = StFault;
            end
            StFault: begin
                if (clr_fault && !unsafe) begin
                    state_d      = StNormal;
                    unsafe_cnt_d = '0;
                    stale_cnt_d  = '0;
                end
            end
            default: state_d = StNormal;
        endcase

        restart = (state_d == StFault) && (state_q != StFault);

        code_d = code_q;
        if (restart) begin
            code_d = conflict ? FC_CONFLICT : (invalid ? FC_INVALID : FC_STALE);
        end else if (state_d == StNormal) begin
            code_d = FC_NONE;
        end

        if (state_d == StNormal) begin
            lamp1_d = decode_lamp(TL1);
            lamp2_d = decode_lamp(TL2);
        end else begin
            lamp1_d = LAMP_R;
            lamp2_d = LAMP_R;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StNormal;
            unsafe_cnt_q <= '0;
            stale_cnt_q  <= '0;
            prev_q       <= '0;
            lamp1_q      <= LAMP_R;
            lamp2_q      <= LAMP_R;
            code_q       <= FC_NONE;
        end else begin
            state_q      <= state_d;
            unsafe_cnt_q <= unsafe_cnt_d;
            stale_cnt_q  <= stale_cnt_d;
            prev_q       <= {TL1, TL2};
            lamp1_q      <= lamp1_d;
            lamp2_q      <= lamp2_d;
            code_q       <= code_d;
        end
    end

    blink_gen #(
        .BLINK_HALF(BLINK_HALF)
    ) u_blink (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .phase  (phase)
    );

    // In FAULT the registered flash phase drives both reds in phase.
    assign lamp1      = (state_q == StFault) ? (phase ? LAMP_R : LAMP_OFF) : lamp1_q;
    assign lamp2      = (state_q == StFault) ? (phase ? LAMP_R : LAMP_OFF) : lamp2_q;
    assign fault      = (state_q == StFault);
    assign fault_code = code_q;

endmodule
